nibble_serial_add_sched: RTL and testbench

NIBBLE_SERIAL_ADD_SCHED -- requirements
Module: nibble_serial_add_sched

---
 rtl/nibble_serial_add_sched.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_add_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_sched.sv
// Two-requester scheduler that time-shares one external 4-bit adder,
// walking each W-bit add/subtract one nibble per cycle, LSB first.
module nibble_serial_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   sub0,
  input  logic                   sub1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   done,
  output logic                   done_id,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_sel;
  logic            r_prio;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic            r_cout;
  logic            r_ovf;
  logic            r_done_id;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            w_req;
  logic            w_pick;
  logic            w_last;
  logic [3:0]      w_anib;
  logic [3:0]      w_bnib;
  logic            w_bmsb;

  assign w_req  = req0 | req1;
  // Both asking: the round-robin pointer decides; else whoever asks.
  assign w_pick = (req0 & req1) ? r_prio : req1;
  assign w_last = (r_idx == LAST);
  assign w_anib = r_a[{r_idx, 2'b00} +: 4];
  assign w_bnib = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_sub}};
  assign w_bmsb = r_b[W-1] ^ r_sub;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    done    = 1'b0;
    busy    = (r_state != S_IDLE);
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_req) w_next = S_RUN;
      end
      (r_state == S_RUN): begin
        add_a   = w_anib;
        add_b   = w_bnib;
        add_cin = r_carry;
        if (w_last) w_next = S_DONE;
      end
      (r_state == S_DONE): begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_sel     <= 1'b0;
      r_prio    <= 1'b0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_done_id <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_a     <= w_pick ? a1 : a0;
            r_b     <= w_pick ? b1 : b0;
            r_sub   <= w_pick ? sub1 : sub0;
            r_carry <= w_pick ? sub1 : sub0;
            r_sel   <= w_pick;
            r_idx   <= '0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
          end
        end
        S_RUN: begin
          r_result[{r_idx, 2'b00} +: 4] <= add_s;
          r_carry <= add_cout;
          r_idx   <= r_idx + ONE;
          if (w_last) begin
            r_cout    <= add_cout;
            r_ovf     <= (r_a[W-1] == w_bmsb) && (add_s[3] != r_a[W-1]);
            r_done_id <= r_sel;
          end
        end
        S_DONE: r_prio <= ~r_sel;
        default: ;
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign result  = r_result;
  assign cout    = r_cout;
  assign ovf     = r_ovf;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_nibble_serial_add_sched.sv
// Directed bench for nibble_serial_add_sched with a behavioural adder
// and a queue of expected completions.
module tb_nibble_serial_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        sub0, sub1;
  logic        gnt0, gnt1;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic [15:0] result;
  logic        cout, ovf, done, done_id, busy;
  logic [4:0]  w_sum;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign w_sum    = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_s    = w_sum[3:0];
  assign add_cout = w_sum[4];

  nibble_serial_add_sched #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sub0(sub0), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .result(result), .cout(cout), .ovf(ovf),
    .done(done), .done_id(done_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [15:0] a,
                                 input logic [15:0] b, input logic s);
    logic [15:0] bb;
    logic [16:0] sum;
    exp_t e;
    bb    = s ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {16'b0, s};
    e.id  = id;
    e.res = sum[15:0];
    e.c   = sum[16];
    e.v   = (a[15] == bb[15]) && (sum[15] != a[15]);
    return e;
  endfunction

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_res"}, result, e.res);
    chk({tag, "_cout"}, cout, e.c);
    chk({tag, "_ovf"}, ovf, e.v);
    chk({tag, "_id"}, done_id, e.id);
  endtask

  task automatic run_op(input string tag, input logic id,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] a_late,
                        input logic [15:0] er, input logic ec,
                        input logic ev);
    logic got;
    sbq.push_back('{id, er, ec, ev});
    if (id) begin a1 = a; b1 = b; sub1 = s; req1 = 1'b1; end
    else    begin a0 = a; b0 = b; sub0 = s; req0 = 1'b1; end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = id ? gnt1 : gnt0;
    end
    chk({tag, "_gnt"}, got, 1);
    chk({tag, "_gnt_other"}, id ? gnt0 : gnt1, 0);
    chk({tag, "_cin0"}, add_cin, s);
    chk({tag, "_a0nib"}, add_a, a[3:0]);
    req0 = 1'b0;
    req1 = 1'b0;
    if (id) begin a1 = a_late; b1 = ~b; sub1 = ~s; end
    else    begin a0 = a_late; b0 = ~b; sub0 = ~s; end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) chk({tag, "_gnt_pulse"}, id ? gnt1 : gnt0, 0);
      chk({tag, "_done_t"}, done, (c == 5) ? 1 : 0);
      chk({tag, "_busy"}, busy, 1);
    end
    pop_cmp(tag);
    chk({tag, "_adda_done"}, add_a, 0);
    @(negedge clk);
    chk({tag, "_idle"}, {done, busy}, 0);
    chk({tag, "_hold"}, result, er);
  endtask

  initial begin
    logic got;
    int   prev;
    exp_t e;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 16'h1111; b0 = 16'h2222; sub0 = 1'b0;
    a1 = 16'h9000; b1 = 16'h1000; sub1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, ovf, done_id}, 0);
    chk("rst_adder", {add_a, add_b, add_cin}, 0);
    rst = 1'b0;

    prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = gnt0 | gnt1;
      end
      chk("rr_gnt_seen", got, 1);
      chk("rr_gnt_id", {gnt1, gnt0}, (k % 2) ? 2'b10 : 2'b01);
      e = (k % 2) ? model(1'b1, a1, b1, sub1) : model(1'b0, a0, b0, sub0);
      sbq.push_back(e);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk);
        got = done;
      end
      chk("rr_done_seen", got, 1);
      pop_cmp("rr");
      if (k > 0) chk("rr_spacing", cyc - prev, 6);
      prev = cyc;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    run_op("add_basic", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h1234,
           16'h2201, 1'b0, 1'b0);
    run_op("sub_neg", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'h0005,
           16'hFFFE, 1'b0, 1'b0);
    run_op("ovf_pos", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF,
           16'h8000, 1'b0, 1'b1);
    run_op("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF,
           16'h0000, 1'b1, 1'b0);
    run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h8000,
           16'h7FFF, 1'b1, 1'b1);

    a0 = 16'h4321; b0 = 16'h1111; sub0 = 1'b0; req0 = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = gnt0;
    end
    chk("abort_gnt", got, 1);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_result", result, 0);
    chk("abort_rst_flags", {cout, ovf, done_id}, 0);
    chk("abort_rst_ctl", {gnt0, gnt1, done, busy}, 0);
    rst = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done | gnt0 | gnt1 | busy) got = 1'b1;
    end
    chk("abort_quiet", got, 0);

    run_op("late_a", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'hFFFF,
           16'h0002, 1'b0, 1'b0);

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
